// File: rtl/csr_hpm_counters.sv
`default_nettype none
// ============================================================================
//  Module   : csr_hpm_counters (with package csr_hpm_pkg)
//  Purpose  : Machine/supervisor hardware performance counters: mcycle,
//             minstret, mhpmcounter3.., mhpmevent3.., mcountinhibit,
//             mcounteren, scounteren plus the user-level read-only shadows.
//  Ports    : clock, reset_n       - clock, asynchronous active-low reset
//             csr_op/csr_addr/
//             wr_data/privilege_mode - CSR access request
//             instret, events      - counting sources
//             rd_data, hit, illegal - combinational access response
//             overflow             - one-cycle wrap pulse per counter
//                                    (bit0 cycle, bit1 instret, bit2+i hpm 3+i)
//  Revision : 1.0 - initial release
// ============================================================================

package csr_hpm_pkg;
    typedef enum logic [2:0] {
        CsrNoOp = 3'd0,
        CsrRW   = 3'd1,
        CsrRS   = 3'd2,
        CsrRC   = 3'd3,
        CsrMret = 3'd4,
        CsrSret = 3'd5
    } csr_op_t;

    typedef enum logic [1:0] {
        PrivUser       = 2'd0,
        PrivSupervisor = 2'd1,
        PrivMachine    = 2'd3
    } privilege_mode_t;
endpackage

module csr_hpm_counters
    import csr_hpm_pkg::*;
#(
    parameter int DATA_SIZE  = 64,
    parameter int NUM_HPM    = 4,
    parameter int HPM_WIDTH  = 40,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  csr_op_t               csr_op,
    input  logic [11:0]           csr_addr,
    input  logic [DATA_SIZE-1:0]  wr_data,
    input  privilege_mode_t       privilege_mode,
    input  logic                  instret,
    input  logic [NUM_EVENTS-1:0] events,
    output logic [DATA_SIZE-1:0]  rd_data,
    output logic                  hit,
    output logic                  illegal,
    output logic [NUM_HPM+1:0]    overflow
);

    localparam int          EV_W     = $clog2(NUM_EVENTS + 1);
    localparam int          EVV_W    = 1 << EV_W;
    localparam int          HPM_N    = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam bit          HIGH_OK  = (DATA_SIZE == 32);
    localparam logic [31:0] HPM_MASK = 32'(((64'd1 << NUM_HPM) - 64'd1) << 3);
    // mcountinhibit[1] (time) is hardwired to zero.
    localparam logic [31:0] INH_MASK = HPM_MASK | 32'h0000_0005;
    localparam logic [31:0] EN_MASK  = HPM_MASK | 32'h0000_0007;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [63:0]           mcycle_q, mcycle_d;
    logic [63:0]           minstret_q, minstret_d;
    logic [HPM_WIDTH-1:0]  hpm_q [HPM_N];
    logic [HPM_WIDTH-1:0]  hpm_d [HPM_N];
    logic [EV_W-1:0]       event_q [HPM_N];
    logic [EV_W-1:0]       event_d [HPM_N];
    logic [31:0]           inhibit_q, inhibit_d;
    logic [31:0]           mcounteren_q, mcounteren_d;
    logic [31:0]           scounteren_q, scounteren_d;
    logic [NUM_HPM+1:0]    overflow_q, overflow_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [6:0] addr_grp;
    logic [4:0] idx;
    logic       hpm_idx_ok, cnt_idx_ok;
    logic       sel_mcnt_lo, sel_mcnt_hi, sel_scnt_lo, sel_scnt_hi;
    logic       sel_inhibit, sel_event, sel_mcen, sel_scen;
    logic       sel_cnt, sel_high, sel_shadow;

    assign addr_grp    = csr_addr[11:5];
    assign idx         = csr_addr[4:0];
    assign hpm_idx_ok  = (int'(idx) >= 3) && (int'(idx) < 3 + NUM_HPM);
    assign cnt_idx_ok  = (idx == 5'd0) || (idx == 5'd2) || hpm_idx_ok;

    assign sel_mcnt_lo = (addr_grp == 7'b1011_000) && cnt_idx_ok;
    assign sel_mcnt_hi = HIGH_OK && (addr_grp == 7'b1011_100) && cnt_idx_ok;
    assign sel_scnt_lo = (addr_grp == 7'b1100_000) && cnt_idx_ok;
    assign sel_scnt_hi = HIGH_OK && (addr_grp == 7'b1100_100) && cnt_idx_ok;
    assign sel_inhibit = (csr_addr == 12'h320);
    assign sel_event   = (addr_grp == 7'b0011_001) && hpm_idx_ok;
    assign sel_mcen    = (csr_addr == 12'h306);
    assign sel_scen    = (csr_addr == 12'h106);

    assign sel_cnt     = sel_mcnt_lo | sel_mcnt_hi | sel_scnt_lo | sel_scnt_hi;
    assign sel_high    = sel_mcnt_hi | sel_scnt_hi;
    assign sel_shadow  = sel_scnt_lo | sel_scnt_hi;
    assign hit         = sel_cnt | sel_inhibit | sel_event | sel_mcen | sel_scen;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [63:0]          cnt_val;
    logic [EV_W-1:0]      ev_val;
    logic [DATA_SIZE-1:0] rd_val;

    always_comb begin
        cnt_val = 64'd0;
        ev_val  = '0;
        if (idx == 5'd0) begin
            cnt_val = mcycle_q;
        end else if (idx == 5'd2) begin
            cnt_val = minstret_q;
        end
        for (int i = 0; i < NUM_HPM; i++) begin
            if (int'(idx) == 3 + i) begin
                cnt_val = 64'(hpm_q[i]);
                ev_val  = event_q[i];
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (sel_cnt) begin
            rd_val = DATA_SIZE'(sel_high ? {32'd0, cnt_val[63:32]} : cnt_val);
        end else if (sel_inhibit) begin
            rd_val = DATA_SIZE'(inhibit_q);
        end else if (sel_event) begin
            rd_val = DATA_SIZE'(ev_val);
        end else if (sel_mcen) begin
            rd_val = DATA_SIZE'(mcounteren_q);
        end else if (sel_scen) begin
            rd_val = DATA_SIZE'(scounteren_q);
        end
    end

    assign rd_data = rd_val;

    // ------------------------------------------------------------------
    // Access checking and write value
    // ------------------------------------------------------------------
    logic                 op_active, wr_eff, fault, wen;
    logic [DATA_SIZE-1:0] wval;
    logic [63:0]          wval64, new64;

    assign op_active = (csr_op == CsrRW) || (csr_op == CsrRS) || (csr_op == CsrRC);
    // Set/clear with a zero operand is a pure read.
    assign wr_eff    = (csr_op == CsrRW) ||
                       (((csr_op == CsrRS) || (csr_op == CsrRC)) && (|wr_data));

    always_comb begin
        case (csr_op)
            CsrRS:   wval = rd_val | wr_data;
            CsrRC:   wval = rd_val & ~wr_data;
            default: wval = wr_data;
        endcase
    end

    always_comb begin
        fault = 1'b0;
        // Address bits [9:8] encode the lowest privilege allowed.
        if ((csr_addr[9:8] == 2'b11) && (privilege_mode != PrivMachine)) begin
            fault = 1'b1;
        end
        if (sel_scen && (privilege_mode == PrivUser)) begin
            fault = 1'b1;
        end
        if (sel_shadow) begin
            if (wr_eff) begin
                fault = 1'b1;
            end
            if ((privilege_mode == PrivSupervisor) && !mcounteren_q[idx]) begin
                fault = 1'b1;
            end
            if ((privilege_mode == PrivUser) &&
                !(mcounteren_q[idx] && scounteren_q[idx])) begin
                fault = 1'b1;
            end
        end
    end

    assign illegal = hit && op_active && fault;
    assign wen     = hit && wr_eff && !illegal;

    // In 32-bit mode a half write keeps the other half of the counter.
    assign wval64 = 64'(wval);
    assign new64  = HIGH_OK ? (sel_high ? {wval64[31:0], cnt_val[31:0]}
                                        : {cnt_val[63:32], wval64[31:0]})
                            : wval64;

    // ------------------------------------------------------------------
    // Next state: CSR writes take priority over counting
    // ------------------------------------------------------------------
    logic [EVV_W-1:0] ev_vec;

    // Selector value 0 maps to a constant-zero slot; unused codes read zero.
    assign ev_vec = EVV_W'({events, 1'b0});

    always_comb begin
        mcycle_d     = mcycle_q;
        minstret_d   = minstret_q;
        hpm_d        = hpm_q;
        event_d      = event_q;
        inhibit_d    = inhibit_q;
        mcounteren_d = mcounteren_q;
        scounteren_d = scounteren_q;
        overflow_d   = '0;

        if (wen && sel_cnt && (idx == 5'd0)) begin
            mcycle_d = new64;
        end else if (!inhibit_q[0]) begin
            mcycle_d      = mcycle_q + 64'd1;
            overflow_d[0] = &mcycle_q;
        end

        if (wen && sel_cnt && (idx == 5'd2)) begin
            minstret_d = new64;
        end else if (instret && !inhibit_q[2]) begin
            minstret_d    = minstret_q + 64'd1;
            overflow_d[1] = &minstret_q;
        end

        for (int i = 0; i < NUM_HPM; i++) begin
            if (wen && sel_cnt && (int'(idx) == 3 + i)) begin
                hpm_d[i] = HPM_WIDTH'(new64);
            end else if (ev_vec[event_q[i]] && !inhibit_q[3 + i]) begin
                hpm_d[i]          = hpm_q[i] + HPM_WIDTH'(1);
                overflow_d[2 + i] = &hpm_q[i];
            end
            if (wen && sel_event && (int'(idx) == 3 + i)) begin
                event_d[i] = (wval64 > 64'(NUM_EVENTS)) ? '0 : EV_W'(wval64);
            end
        end

        if (wen && sel_inhibit) begin
            inhibit_d = wval64[31:0] & INH_MASK;
        end
        if (wen && sel_mcen) begin
            mcounteren_d = wval64[31:0] & EN_MASK;
        end
        if (wen && sel_scen) begin
            scounteren_d = wval64[31:0] & EN_MASK;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcycle_q     <= 64'd0;
            minstret_q   <= 64'd0;
            for (int i = 0; i < HPM_N; i++) begin
                hpm_q[i]   <= '0;
                event_q[i] <= '0;
            end
            inhibit_q    <= 32'd0;
            mcounteren_q <= 32'd0;
            scounteren_q <= 32'd0;
            overflow_q   <= '0;
        end else begin
            mcycle_q     <= mcycle_d;
            minstret_q   <= minstret_d;
            hpm_q        <= hpm_d;
            event_q      <= event_d;
            inhibit_q    <= inhibit_d;
            mcounteren_q <= mcounteren_d;
            scounteren_q <= scounteren_d;
            overflow_q   <= overflow_d;
        end
    end

    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: doc/csr_hpm_counters.md
CSR_HPM_COUNTERS -- requirements
Module: csr_hpm_counters

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, meaning CSR data width (32 or 64 only).
REQ-002 SHALL have parameter NUM_HPM, default 4, meaning number of mhpmcounter/mhpmevent pairs, indices 3..3+NUM_HPM-1, legal range 0..29.
REQ-003 SHALL have parameter HPM_WIDTH, default 40, meaning implemented hpm counter bits (40..64); upper bits read zero.
REQ-004 SHALL have parameter NUM_EVENTS, default 8, meaning event input count (1..255).
REQ-005 SHALL have ports, in order: clock  in  1  system clock; reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: csr_op  in  csr_op_t  CsrNoOp/CsrRW/CsrRS/CsrRC (CsrMret/CsrSret treated as CsrNoOp); csr_addr  in  12  CSR address; wr_data  in  DATA_SIZE  write/set/clear operand; privilege_mode  in  privilege_mode_t  current privilege.
REQ-007 SHALL have ports: instret  in  1  instruction-retired pulse; events  in  NUM_EVENTS  event pulses, one bit per event.
REQ-008 SHALL have ports: rd_data  out  DATA_SIZE  read value; hit  out  1  address decoded by this block; illegal  out  1  access fault; overflow  out  NUM_HPM+2  per-counter wrap pulse (bit0 cycle, bit1 instret, bit2+i hpm 3+i).

Function
REQ-009 SHALL decode: mcycle B00, minstret B02, mhpmcounterN B00+N, mcountinhibit 320, mhpmeventN 320+N, mcounteren 306, scounteren 106, cycle C00, instret C02, hpmcounterN C00+N; when DATA_SIZE=32 also high halves B80/B82/B80+N and C80/C82/C80+N.
REQ-010 SHALL drive hit=1 only for decoded addresses; unimplemented hpm indices and high halves when DATA_SIZE=64 give hit=0, rd_data=0, illegal=0.
REQ-011 SHALL produce rd_data and illegal combinationally in the same cycle; writes take effect at the next rising clock edge.
REQ-012 SHALL flag illegal for: any M-level address (B__, 3__) below Machine; scounteren below Supervisor; any write (non-NoOp with effective write) to C__/C8_ shadows; shadow read at Supervisor with mcounteren[idx]=0; shadow read at User with mcounteren[idx]=0 or scounteren[idx]=0.
REQ-013 SHALL suppress the write when illegal=1; illegal shall be 0 when csr_op=CsrNoOp.
REQ-014 SHALL compute new value: RW=wr_data, RS=old|wr_data, RC=old&~wr_data; RS/RC with wr_data=0 perform no write and are never illegal for the write rule.
REQ-015 SHALL increment mcycle every cycle when mcountinhibit[0]=0; minstret when instret=1 and mcountinhibit[2]=0; hpm N when selected event bit is 1 and mcountinhibit[N]=0.
REQ-016 SHALL hold mcycle/minstret at 64 bits, hpm counters at HPM_WIDTH bits, all wrapping modulo 2^width.
REQ-017 SHALL store mhpmevent as clog2(NUM_EVENTS+1)-bit WARL field: 0 counts nothing, k in 1..NUM_EVENTS selects events[k-1], written values above NUM_EVENTS store 0.
REQ-018 SHALL hardwire mcountinhibit[1], mcounteren[1]-irrelevant? no: mcountinhibit[1]=0, and bits of mcountinhibit/mcounteren/scounteren beyond implemented counters read 0.
REQ-019 SHALL give CSR write priority: counter written in a cycle takes the written value and does not increment that cycle; a low- or high-half write (DATA_SIZE=32) preserves the other half and also suppresses that cycle's increment.
REQ-020 SHALL pulse overflow bit for one cycle when a counter wraps all-ones to zero by increment; writes never raise overflow.
REQ-021 SHALL apply a same-cycle mcountinhibit write from the next cycle; counting in the write cycle uses the old inhibit value.

Reset
REQ-022 SHALL on reset_n=0, asynchronously clear all counters, mhpmevent, mcountinhibit, mcounteren, scounteren and overflow; rd_data reflects cleared state.
REQ-023 SHALL start counting mcycle on the first rising edge after reset_n deasserts; reset asserted mid-write discards the write.

Verification
REQ-024 Reset, 10 idle cycles, Machine read B00 -> rd_data=10, hit=1, illegal=0.
REQ-025 RW mhpmcounter3=2^40-1 (HPM_WIDTH=40), mhpmevent3=1, pulse events[0] -> counter=0, overflow[2] one-cycle pulse.
REQ-026 RW minstret=100 in same cycle as instret=1 -> minstret=100 next cycle, not 101.
REQ-027 User reads C00 with mcounteren=1, scounteren=0 -> illegal=1; set scounteren=1 -> illegal=0, rd_data=mcycle.
REQ-028 DATA_SIZE=32: RW B80=5 while low half=7 -> mcycle=0x0000_0005_0000_0007 next cycle; RS C00 wr_data=1 -> illegal=1, no change.
